// File: rtl/line_buffer_taps.sv
// Cascaded line-delay taps built on a single wide memory with a registered read port.
// Each ce cycle reads the word at pos, then overwrites it with {older taps, din}.
module line_buffer_taps #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned LINES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      h_size,
    input  logic [WIDTH-1:0]       din,
    output logic [LINES*WIDTH-1:0] taps,
    output logic [LINES-1:0]       tap_valid,
    output logic                   line_end
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned FW    = ADDR_W + 4;
    localparam int unsigned TW    = LINES * WIDTH;

    logic [ADDR_W-1:0] h_clamp;
    logic [ADDR_W-1:0] h_act_q, h_act_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [ADDR_W-1:0] pos_last;
    logic [FW-1:0]     fill_q, fill_d;
    logic [FW-1:0]     fill_max;
    logic [TW-1:0]     rd_q, rd_d;
    logic [TW-1:0]     wr_data;
    logic              wr_en;
    logic [TW-1:0]     mem_q [DEPTH];

    assign h_clamp  = (h_size < ADDR_W'(3)) ? ADDR_W'(3) : h_size;
    assign pos_last = h_act_q - ADDR_W'(2);
    assign fill_max = FW'(LINES) * FW'(h_act_q);
    assign line_end = ce & (pos_q == pos_last);
    assign wr_en    = rst_n & ce & ~flush;

    // Slice 0 of the stored word is the fresh sample; older taps shift up one slot.
    if (LINES > 1) begin : g_cascade
        assign wr_data = {rd_q[(LINES-1)*WIDTH-1:0], din};
    end else begin : g_single
        assign wr_data = din;
    end

    always_comb begin
        pos_d   = pos_q;
        fill_d  = fill_q;
        h_act_d = h_act_q;
        rd_d    = rd_q;
        if (flush) begin
            pos_d   = '0;
            fill_d  = '0;
            h_act_d = h_clamp;
        end else if (ce) begin
            rd_d  = mem_q[pos_q];
            pos_d = line_end ? '0 : pos_q + ADDR_W'(1);
            if (fill_q < fill_max) begin
                fill_d = fill_q + FW'(1);
            end
            if (line_end) begin
                h_act_d = h_clamp;
                // Data laid down with the old period no longer lines up with the new one.
                if (h_clamp != h_act_q) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q   <= '0;
            fill_q  <= '0;
            h_act_q <= h_clamp;
            rd_q    <= '0;
        end else begin
            pos_q   <= pos_d;
            fill_q  <= fill_d;
            h_act_q <= h_act_d;
            rd_q    <= rd_d;
        end
    end

    // Non-blocking write lets the same-cycle read above see the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[pos_q] <= wr_data;
        end
    end

    always_comb begin
        tap_valid = '0;
        taps      = '0;
        for (int k = 0; k < int'(LINES); k++) begin
            tap_valid[k] = fill_q >= (FW'(k + 1) * FW'(h_act_q));
            if (tap_valid[k]) begin
                taps[k*WIDTH +: WIDTH] = rd_q[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Scoreboard bench for line_buffer_taps: a history-based reference model predicts
// taps, tap_valid and line_end for every cycle; predictions are queued and compared.
module tb_line_buffer_taps;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned LINES  = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ce;
    logic                   flush;
    logic [ADDR_W-1:0]      h_size;
    logic [WIDTH-1:0]       din;
    logic [LINES*WIDTH-1:0] taps;
    logic [LINES-1:0]       tap_valid;
    logic                   line_end;

    line_buffer_taps #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W),
        .LINES (LINES)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .flush    (flush),
        .h_size   (h_size),
        .din      (din),
        .taps     (taps),
        .tap_valid(tap_valid),
        .line_end (line_end)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LINES*WIDTH-1:0] taps;
        logic [LINES-1:0]       valid;
        logic                   le;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: samples since the last period restart, and the active period.
    int   hist[$];
    int   h_m;
    int   n_m;
    int   din_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int h);
        return (h < 3) ? 3 : h;
    endfunction

    function automatic exp_t predict(input logic c);
        exp_t e;
        e = '0;
        for (int k = 0; k < int'(LINES); k++) begin
            if (n_m >= (k + 1) * h_m) begin
                e.valid[k] = 1'b1;
                e.taps[k*WIDTH +: WIDTH] = WIDTH'(hist[n_m - (k + 1) * h_m]);
            end
        end
        e.le = c && ((n_m % (h_m - 1)) == (h_m - 2));
        return e;
    endfunction

    task automatic model_restart();
        h_m = clamp(int'(h_size));
        n_m = 0;
        hist.delete();
    endtask

    // One clock: drive, predict, compare mid-cycle, then advance the model past the edge.
    task automatic step(input logic c, input logic f, input logic r);
        exp_t e;
        exp_t g;
        int   newh;
        logic le;
        ce    = c;
        flush = f;
        rst_n = r;
        din   = WIDTH'(din_cnt);
        exp_q.push_back(predict(c));
        #2;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            g.taps  = taps;
            g.valid = tap_valid;
            g.le    = line_end;
            check_eq("taps", 32'(g.taps), 32'(e.taps));
            check_eq("tap_valid", 32'(g.valid), 32'(e.valid));
            check_eq("line_end", 32'(g.le), 32'(e.le));
        end
        @(posedge clk);
        #1;
        if (!r || f) begin
            model_restart();
        end else if (c) begin
            le = (n_m % (h_m - 1)) == (h_m - 2);
            hist.push_back(din_cnt);
            n_m++;
            if (le) begin
                newh = clamp(int'(h_size));
                if (newh != h_m) begin
                    h_m = newh;
                    n_m = 0;
                    hist.delete();
                end
            end
        end
        if (c && r && !f) begin
            din_cnt = (din_cnt + 1) % 256;
        end
    endtask

    task automatic run(input int cycles, input logic c);
        for (int i = 0; i < cycles; i++) begin
            step(c, 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ce     = 1'b0;
        flush  = 1'b0;
        h_size = ADDR_W'(6);
        din    = '0;
        repeat (2) @(posedge clk);
        #1;
        model_restart();

        // Reset state, then a continuous stream with h_size=6.
        step(1'b1, 1'b0, 1'b0);
        run(40, 1'b1);
        if (n_m >= 18) begin
            check_eq("all_valid_h6", 32'(tap_valid), 32'b111);
        end

        // ce alternating: outputs must hold while ce is low.
        for (int i = 0; i < 30; i++) begin
            step(i[0] == 1'b0, 1'b0, 1'b1);
        end

        // Period change mid-line takes effect only at the next line end.
        run(2, 1'b1);
        h_size = ADDR_W'(8);
        run(40, 1'b1);

        // Undersized line length behaves as 3.
        h_size = ADDR_W'(1);
        run(20, 1'b1);

        // Flush with ce high, then refill at h_size=6.
        h_size = ADDR_W'(6);
        run(20, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_eq("flush_valid", 32'(tap_valid), 32'b000);
        check_eq("flush_taps", 32'(taps), 32'd0);
        run(25, 1'b1);

        // Single-cycle reset mid-stream.
        step(1'b1, 1'b0, 1'b0);
        check_eq("rst_valid", 32'(tap_valid), 32'b000);
        check_eq("rst_taps", 32'(taps), 32'd0);
        run(25, 1'b1);

        // Random ce and occasional flush at h_size=5.
        h_size = ADDR_W'(5);
        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
